tempo_ctrl: RTL

- Front-panel tempo controller that owns the BPM setting consumed by the metronome beat datapath on its `speed` input.
- Synchronises and debounces five push-buttons, turns each into single step events, and applies those events to a saturating 8-bit BPM register.
- Replaces free-running, wrapping per-clock increments with one step per press, plus optional hold-to-repeat.
- Sits between the board buttons and the metronome; same `clk` domain.

---
 rtl/tempo_ctrl_if.sv | 22 ++
 rtl/tempo_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/tempo_ctrl_if.sv
// Front-panel button / tempo bus between the board buttons and tempo_ctrl.
// master drives the raw buttons, slave (tempo_ctrl) drives the BPM outputs.
interface tempo_ctrl_if;
    logic       btn_left;
    logic       btn_right;
    logic       btn_down;
    logic       btn_up;
    logic       btn_center;
    logic [7:0] speed;
    logic       speed_chg;
    logic       at_limit;

    modport master (
        output btn_left, btn_right, btn_down, btn_up, btn_center,
        input  speed, speed_chg, at_limit
    );

    modport slave (
        input  btn_left, btn_right, btn_down, btn_up, btn_center,
        output speed, speed_chg, at_limit
    );
endinterface

// File: rtl/tempo_ctrl.sv
// Tempo controller: debounced push-buttons step a saturating BPM register.
// Optional hold-to-repeat is built when AUTO_REPEAT_EN is defined.
module tempo_ctrl #(
    parameter int unsigned DEF_BPM       = 60,
    parameter int unsigned MIN_BPM       = 30,
    parameter int unsigned MAX_BPM       = 250,
    parameter int unsigned DEB_CYCLES    = 250000,
    parameter int unsigned HOLD_CYCLES   = 12500000,
    parameter int unsigned REPEAT_CYCLES = 2500000
) (
    input  logic         clk,
    input  logic         rst,
    tempo_ctrl_if.slave  bus
);

    localparam int unsigned NUM_BTN  = 5;
    localparam int unsigned CNT_MAX0 = (DEB_CYCLES > HOLD_CYCLES) ? DEB_CYCLES : HOLD_CYCLES;
    localparam int unsigned CNT_MAX  = (CNT_MAX0 > REPEAT_CYCLES) ? CNT_MAX0 : REPEAT_CYCLES;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam int unsigned DEB_LAST = (DEB_CYCLES >= 2) ? DEB_CYCLES - 2 : 0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DEB_P  = 3'd1,
        HELD   = 3'd2,
        DEB_R  = 3'd3,
        REPEAT = 3'd4
    } btn_state_e;

    // Bit order doubles as arbitration priority: center, left, right, down, up.
    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] sync1;
    logic [NUM_BTN-1:0] s;
    logic [NUM_BTN-1:0] ev;
    logic [1:0]         primed;
    logic [7:0]         speed_q;
    logic               chg_q;
    logic [7:0]         nxt_c;

    assign raw = {bus.btn_up, bus.btn_down, bus.btn_right, bus.btn_left, bus.btn_center};

    // Two-flop synchronisers; primed marks when s reflects post-reset button levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '0;
            s      <= '0;
            primed <= '0;
        end else begin
            sync1  <= raw;
            s      <= sync1;
            primed <= {primed[0], 1'b1};
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_state_e       st;
        logic [CNT_W-1:0] cnt;
        logic             ev_q;
        logic             arm;

        assign ev[i] = ev_q;

        // A button held through reset must be seen released before it can step.
        always_ff @(posedge clk) begin
            if (rst) begin
                st   <= IDLE;
                cnt  <= '0;
                ev_q <= 1'b0;
                arm  <= 1'b0;
            end else begin
                ev_q <= 1'b0;
                if (primed[1] && !s[i]) begin
                    arm <= 1'b1;
                end
                unique case (st)
                    IDLE: begin
                        cnt <= '0;
                        if (s[i] && arm) begin
                            st <= DEB_P;
                        end
                    end
                    DEB_P: begin
                        if (!s[i]) begin
                            st <= IDLE;
                        end else if (cnt == CNT_W'(DEB_LAST)) begin
                            st   <= HELD;
                            cnt  <= '0;
                            ev_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    HELD: begin
                        if (!s[i]) begin
                            st  <= DEB_R;
                            cnt <= '0;
                        end
`ifdef AUTO_REPEAT_EN
                        else if (i != 0) begin
                            if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                                st   <= REPEAT;
                                cnt  <= '0;
                                ev_q <= 1'b1;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
`endif
                    end
`ifdef AUTO_REPEAT_EN
                    REPEAT: begin
                        if (!s[i]) begin
                            st  <= DEB_R;
                            cnt <= '0;
                        end else if (cnt == CNT_W'(REPEAT_CYCLES - 1)) begin
                            cnt  <= '0;
                            ev_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
`endif
                    DEB_R: begin
                        if (s[i]) begin
                            st  <= HELD;
                            cnt <= '0;
                        end else if (cnt == CNT_W'(DEB_LAST)) begin
                            st  <= IDLE;
                            cnt <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        st  <= IDLE;
                        cnt <= '0;
                    end
                endcase
            end
        end
    end

    function automatic logic [7:0] step_up(input logic [7:0] v, input logic [7:0] d);
        logic [8:0] t;
        t = {1'b0, v} + {1'b0, d};
        return (t > 9'(MAX_BPM)) ? 8'(MAX_BPM) : t[7:0];
    endfunction

    function automatic logic [7:0] step_dn(input logic [7:0] v, input logic [7:0] d);
        return ({1'b0, v} < ({1'b0, d} + 9'(MIN_BPM))) ? 8'(MIN_BPM) : (v - d);
    endfunction

    // Highest-priority event wins; the others are dropped.
    always_comb begin
        nxt_c = speed_q;
        if (ev[0]) begin
            nxt_c = 8'(DEF_BPM);
        end else if (ev[1]) begin
            nxt_c = step_dn(speed_q, 8'd1);
        end else if (ev[2]) begin
            nxt_c = step_up(speed_q, 8'd1);
        end else if (ev[3]) begin
            nxt_c = step_dn(speed_q, 8'd10);
        end else if (ev[4]) begin
            nxt_c = step_up(speed_q, 8'd10);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            speed_q <= 8'(DEF_BPM);
            chg_q   <= 1'b0;
        end else begin
            chg_q <= 1'b0;
            if (nxt_c != speed_q) begin
                speed_q <= nxt_c;
                chg_q   <= 1'b1;
            end
        end
    end

    assign bus.speed     = speed_q;
    assign bus.speed_chg = chg_q;
    assign bus.at_limit  = (speed_q == 8'(MIN_BPM)) || (speed_q == 8'(MAX_BPM));

endmodule
